// File: rtl/dmem_loader_if.sv
// Byte-stream input and memory port-B write bus of the data-memory loader.
// slave is the loader's view; master is the host/memory-side view.
interface dmem_loader_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [31:0] addr_b;
  logic [31:0] din_b;
  logic        we_b;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  s_valid, s_data,
    output s_ready, addr_b, din_b, we_b, busy, done, err
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, addr_b, din_b, we_b, busy, done, err
  );
endinterface

// File: rtl/dmem_loader.sv
// Parses framed load records (base, count, data words) from a byte stream and
// issues little-endian 32-bit word writes to data-memory port B.
module dmem_loader #(
  parameter int unsigned DEPTH = 12
) (
  input  logic          clk,
  input  logic          reset,
  dmem_loader_if.slave  bus
);

  localparam int unsigned HI_LSB = DEPTH + 2;

  typedef enum logic [1:0] {
    HDR_ADDR = 2'd0,
    HDR_LEN  = 2'd1,
    DATA     = 2'd2,
    FIN      = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] word_q, word_d;
  logic [29:0] base_q, base_d;
  logic [31:0] remain_q, remain_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] addr_b_q, addr_b_d;
  logic [31:0] din_b_q, din_b_d;
  logic        we_b_q, we_b_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        s_ready_q, s_ready_d;

  logic        xfer;
  logic        last_byte;
  logic [31:0] word_full;
  logic        in_range;

  assign xfer      = bus.s_valid & s_ready_q;
  assign last_byte = xfer && (cnt_q == 2'd3);
  // The 4th byte is taken straight from the stream, so only 3 lanes are stored.
  assign word_full = {bus.s_data, word_q};
  assign in_range  = (cur_addr_q >> HI_LSB) == 32'(0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    base_d     = base_q;
    remain_d   = remain_q;
    cur_addr_d = cur_addr_q;
    addr_b_d   = addr_b_q;
    din_b_d    = din_b_q;
    we_b_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;

    if (xfer) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    word_d[7:0]   = bus.s_data;
        2'd1:    word_d[15:8]  = bus.s_data;
        2'd2:    word_d[23:16] = bus.s_data;
        default: word_d        = word_q;
      endcase
    end

    case (state_q)
      HDR_ADDR: begin
        if (xfer && (cnt_q == 2'd0)) err_d = 1'b0;
        if (last_byte) begin
          base_d  = word_full[31:2];
          state_d = HDR_LEN;
        end
      end
      HDR_LEN: begin
        if (last_byte) begin
          remain_d   = word_full;
          cur_addr_d = {base_q, 2'b00};
          if (word_full == 32'd0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (last_byte) begin
          // Out-of-range words are consumed silently and flagged.
          if (in_range) begin
            we_b_d   = 1'b1;
            addr_b_d = cur_addr_q;
            din_b_d  = word_full;
          end else begin
            err_d = 1'b1;
          end
          cur_addr_d = cur_addr_q + 32'd4;
          remain_d   = remain_q - 32'd1;
          if (remain_q == 32'd1) begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      FIN:     state_d = HDR_ADDR;
      default: state_d = HDR_ADDR;
    endcase

    s_ready_d = (state_d != FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= HDR_ADDR;
      cnt_q      <= 2'd0;
      word_q     <= 24'd0;
      base_q     <= 30'd0;
      remain_q   <= 32'd0;
      cur_addr_q <= 32'd0;
      addr_b_q   <= 32'd0;
      din_b_q    <= 32'd0;
      we_b_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      s_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      base_q     <= base_d;
      remain_q   <= remain_d;
      cur_addr_q <= cur_addr_d;
      addr_b_q   <= addr_b_d;
      din_b_q    <= din_b_d;
      we_b_q     <= we_b_d;
      done_q     <= done_d;
      err_q      <= err_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.addr_b  = addr_b_q;
  assign bus.din_b   = din_b_q;
  assign bus.we_b    = we_b_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.busy    = (state_q != HDR_ADDR) || (cnt_q != 2'd0);

endmodule
